// File: rtl/approx_pkg.sv
// Shared defaults and types for the truncating approximate adder pipeline.
package approx_pkg;

  // Default configuration of approx_adder_pipe.
  localparam int APPROX_WIDTH  = 16;
  localparam int APPROX_TRUNC  = 12;
  localparam int APPROX_STAGES = 2;
  localparam int APPROX_ACC_W  = 48;

  // Widest per-sample error the record must carry (TRUNC can reach 63).
  localparam int APPROX_MAX_ERR_W = 64;

  // Per-sample error record handed from the last pipeline stage to the stats block.
  typedef struct packed {
    logic [APPROX_MAX_ERR_W-1:0] err;
    logic                        vld;
  } err_rec_t;

endpackage

// File: rtl/approx_stats.sv
// Error statistics: saturating error sum, running maximum and saturating
// sample count, updated once per output handshake.
module approx_stats
  import approx_pkg::*;
#(
  parameter int ACC_W = APPROX_ACC_W,
  parameter int ERR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_hs,
  input  err_rec_t         i_rec,
  output logic [ACC_W-1:0] o_acc,
  output logic [ERR_W-1:0] o_max,
  output logic [31:0]      o_cnt
);

  // Headroom wide enough to detect overflow of either operand.
  localparam int                SUM_W   = ((ACC_W > APPROX_MAX_ERR_W) ? ACC_W : APPROX_MAX_ERR_W) + 1;
  localparam logic [ACC_W-1:0]  ACC_MAX = '1;

  logic [ACC_W-1:0] r_acc;
  logic [ERR_W-1:0] r_max;
  logic [31:0]      r_cnt;
  logic             w_take;

  // Saturating accumulate of an error value onto a running sum.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] base,
                                               input logic [APPROX_MAX_ERR_W-1:0] add);
    logic [SUM_W-1:0] s;
    s = SUM_W'(base) + SUM_W'(add);
    if (s > SUM_W'(ACC_MAX)) return ACC_MAX;
    return ACC_W'(s);
  endfunction

  assign w_take = i_hs & i_rec.vld;

  // Statistics registers; a clear coinciding with a retiring sample restarts from that sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      if (w_take) begin
        r_acc <= sat_acc('0, i_rec.err);
        r_max <= ERR_W'(i_rec.err);
        r_cnt <= 32'd1;
      end else begin
        r_acc <= '0;
        r_max <= '0;
        r_cnt <= '0;
      end
    end else if (w_take) begin
      r_acc <= sat_acc(r_acc, i_rec.err);
      if (i_rec.err > APPROX_MAX_ERR_W'(r_max)) r_max <= ERR_W'(i_rec.err);
      if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_acc = r_acc;
  assign o_max = r_max;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/approx_adder_pipe.sv
// Pipelined approximate adder: exact WIDTH+1 bit sum with the low TRUNC bits
// zeroed, carried through a valid-tagged shift register with a global stall.
// Optional macro APPROX_ERR_STATS_EN adds the exact-error path and the
// approx_stats block with its ports.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int  WIDTH  = APPROX_WIDTH,
  parameter int  TRUNC  = APPROX_TRUNC,
  parameter int  STAGES = APPROX_STAGES,
  parameter int  ACC_W  = APPROX_ACC_W,
  localparam int ERR_W  = (TRUNC > 0) ? TRUNC : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef APPROX_ERR_STATS_EN
  input  logic             stats_clr,
  output logic [ACC_W-1:0] err_acc,
  output logic [ERR_W-1:0] err_max,
  output logic [31:0]      err_cnt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  // Ones over the truncated low bits; zero when nothing is truncated.
  localparam logic [WIDTH:0] LOW_MASK = ((WIDTH+1)'(1) << TRUNC) - (WIDTH+1)'(1);

  logic [WIDTH:0]    w_exact;
  logic [WIDTH:0]    w_approx;
  logic              w_stall;
  logic [STAGES-1:0] r_vld;
  logic [WIDTH:0]    r_sum [STAGES];

  // Full-precision add first so the carry out of the dropped bits still reaches the kept bits.
  assign w_exact  = (WIDTH+1)'(in_a) + (WIDTH+1)'(in_b);
  assign w_approx = w_exact & ~LOW_MASK;

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;

  // Valid-tagged sum shift register; everything freezes while the output is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) r_sum[i] <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= in_valid;
      r_sum[0] <= w_approx;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_sum[i] <= r_sum[i-1];
      end
    end
  end

`ifdef APPROX_ERR_STATS_EN
  logic [ERR_W-1:0] w_err;
  logic [ERR_W-1:0] r_err [STAGES];
  err_rec_t         w_rec;
  logic             w_out_hs;

  // Dropped low bits are exactly the error; forced to zero when TRUNC is zero by the mask.
  assign w_err = ERR_W'(w_exact & LOW_MASK);

  // Error shadow pipeline; data only, its validity comes from r_vld.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_err[0] <= w_err;
      for (int i = 1; i < STAGES; i++) r_err[i] <= r_err[i-1];
    end
  end

  assign w_rec.err = APPROX_MAX_ERR_W'(r_err[STAGES-1]);
  assign w_rec.vld = r_vld[STAGES-1];
  assign w_out_hs  = out_valid & out_ready;

  approx_stats #(
    .ACC_W (ACC_W),
    .ERR_W (ERR_W)
  ) u_stats (
    .clk   (clk),
    .rst   (rst),
    .i_clr (stats_clr),
    .i_hs  (w_out_hs),
    .i_rec (w_rec),
    .o_acc (err_acc),
    .o_max (err_max),
    .o_cnt (err_cnt)
  );
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed self-checking bench for approx_adder_pipe (WIDTH=16, TRUNC=12, STAGES=2).
// Statistics checks are compiled only when APPROX_ERR_STATS_EN is defined.
module tb_approx_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_sum;
  logic        stats_clr;
`ifdef APPROX_ERR_STATS_EN
  logic [47:0] err_acc;
  logic [11:0] err_max;
  logic [31:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] bp_a   [4] = '{16'h1000, 16'h2000, 16'h3800, 16'h8000};
  logic [15:0] bp_b   [4] = '{16'h0001, 16'h0FFF, 16'h0800, 16'h9000};
  logic [16:0] bp_exp [4] = '{17'h01000, 17'h02000, 17'h04000, 17'h11000};
  logic [16:0] got [$];

  approx_adder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef APPROX_ERR_STATS_EN
    .stats_clr (stats_clr),
    .err_acc   (err_acc),
    .err_max   (err_max),
    .err_cnt   (err_cnt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated sample through an empty pipeline; clr asserts stats_clr in its handshake cycle.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] exp, input logic clr, input string tag);
    check({tag, "_empty"}, 64'(out_valid), 64'd0);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(out_sum), 64'(exp));
    stats_clr = clr;
    tick();
    stats_clr = 1'b0;
    check({tag, "_done"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int idx;
    int seen;
    logic acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    stats_clr = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef APPROX_ERR_STATS_EN
    check("rst_err_acc", 64'(err_acc), 64'd0);
    check("rst_err_max", 64'(err_max), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Carry out of the truncated field reaches bit 12.
    send_one(16'h0FFF, 16'h0001, 17'h01000, 1'b0, "carry");

    // Fresh statistics, then two samples with known errors.
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`ifdef APPROX_ERR_STATS_EN
    check("clr_err_acc", 64'(err_acc), 64'd0);
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
`endif
    send_one(16'h0123, 16'h0456, 17'h00000, 1'b0, "small");
    send_one(16'hFFFF, 16'hFFFF, 17'h1F000, 1'b0, "maxop");
`ifdef APPROX_ERR_STATS_EN
    check("two_err_acc", 64'(err_acc), 64'h1577);
    check("two_err_max", 64'(err_max), 64'hFFE);
    check("two_err_cnt", 64'(err_cnt), 64'd2);
`endif

    // Backpressure: out_ready low for 5 cycles while 4 pairs are offered back to back.
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_in_ready_low", 64'(in_ready),  64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        check("bp_sum_hold",     64'(out_sum),   64'h01000);
      end
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_a = bp_a[idx];
        in_b = bp_b[idx];
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_sum);
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(idx), 64'd4);
    check("bp_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(bp_exp[i]));

    // Clear coinciding with a retiring sample of error 0x010.
    send_one(16'h0008, 16'h0008, 17'h00000, 1'b1, "clr_hs");
`ifdef APPROX_ERR_STATS_EN
    check("clrhs_err_acc", 64'(err_acc), 64'h10);
    check("clrhs_err_max", 64'(err_max), 64'h10);
    check("clrhs_err_cnt", 64'(err_cnt), 64'd1);
`endif

    // Reset with two samples in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h0100;
    in_b      = 16'h0200;
    tick();
    in_a = 16'h0300;
    in_b = 16'h0400;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_sum",   64'(out_sum),   64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
`ifdef APPROX_ERR_STATS_EN
    check("mrst_err_acc", 64'(err_acc), 64'd0);
    check("mrst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mrst_no_ghost", 64'(seen), 64'd0);

    // Sample count saturation.
`ifdef APPROX_ERR_STATS_EN
    force dut.u_stats.r_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.u_stats.r_cnt;
`endif
    send_one(16'h0001, 16'h0002, 17'h00000, 1'b0, "sat");
`ifdef APPROX_ERR_STATS_EN
    check("sat_err_cnt", 64'(err_cnt), 64'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
